// File: rtl/id_ex_pipe_skid.sv
// Two-entry (main + skid) pipeline register with valid/ready handshake, flush and NOP control.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module id_ex_pipe_skid #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 4,
  parameter int REG_W    = 5,
  parameter int NUM_REG  = 3,
  parameter int CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [NUM_REG*REG_W-1:0]   in_reg,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [NUM_REG*REG_W-1:0]   out_reg,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [31:0]                stall_cnt
);

  localparam int DW = NUM_DATA * DATA_W;
  localparam int RW = NUM_REG * REG_W;

  logic          main_valid, skid_valid, ready_q;
  logic [DW-1:0] main_data, skid_data;
  logic [RW-1:0] main_reg, skid_reg;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic accept, drain;
  logic main_valid_n, skid_valid_n;
  logic load_in, load_from_skid, load_skid;

  always_comb begin
    accept         = in_valid & ready_q;
    drain          = ~main_valid | out_ready;
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    load_in        = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (drain) begin
      // A full skid implies in_ready was low, so no new beat competes with it.
      if (skid_valid) begin
        load_from_skid = 1'b1;
        main_valid_n   = 1'b1;
        skid_valid_n   = 1'b0;
      end else if (accept) begin
        load_in      = 1'b1;
        main_valid_n = 1'b1;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
      main_data  <= '0;
      main_reg   <= '0;
      main_ctrl  <= CTRL_NOP;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      ready_q    <= ~skid_valid_n;
      if (load_in) begin
        main_data <= in_data;
        main_reg  <= in_reg;
        main_ctrl <= in_ctrl;
      end else if (load_from_skid) begin
        main_data <= skid_data;
        main_reg  <= skid_reg;
        main_ctrl <= skid_ctrl;
      end
    end
  end

  // Skid payload is only meaningful while skid_valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data <= in_data;
      skid_reg  <= in_reg;
      skid_ctrl <= in_ctrl;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_reg   = main_reg;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_NOP;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (main_valid && !out_ready && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_skid.sv
// Self-checking bench for id_ex_pipe_skid: directed vector table, stall-counter sequence,
// and randomized traffic compared against a queue-based model of the stage.
module tb_id_ex_pipe_skid;

  localparam int DW = 128;
  localparam int RW = 15;
  localparam logic [15:0] NOP = 16'h0000;

  typedef struct {
    logic [DW-1:0] data;
    logic [RW-1:0] regs;
    logic [15:0]   ctrl;
  } beat_t;

  typedef struct {
    bit rst, flush, iv, ordy;
    logic [7:0] tag;
    bit ov, ir;
    logic [7:0] otag;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [RW-1:0] in_reg, out_reg;
  logic [15:0]   in_ctrl, out_ctrl;
  logic [31:0]   stall_cnt;

  int nChecks = 0;
  int nFails  = 0;

  beat_t      mq[$];
  bit         mRdy = 1'b0;
  logic [31:0] mStall = 32'd0;

  id_ex_pipe_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_reg(in_reg), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_reg(out_reg), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic beat_t beatFromTag(input logic [7:0] tag);
    beat_t b;
    b.data = {24'd0, tag + 8'd3, 24'd0, tag + 8'd2, 24'd0, tag + 8'd1, 24'd0, tag};
    b.regs = {1'b0, tag[7:4], tag[4:0], ~tag[4:0]};
    b.ctrl = {8'h01, tag};
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model with the pre-edge inputs, then compare.
  task automatic applyStimulus(input bit r, input bit f, input bit iv, input bit ordy, input beat_t b);
    bit preOv, preRdy;
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    in_data = b.data; in_reg = b.regs; in_ctrl = b.ctrl;
    preOv  = (mq.size() > 0);
    preRdy = mRdy;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      mRdy   = 1'b0;
      mStall = 32'd0;
    end else begin
`ifdef PIPE_STALL_CNT_EN
      if (preOv && !ordy && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
`endif
      if (f) begin
        mq.delete();
        mRdy = 1'b1;
      end else begin
        if (preOv && ordy) void'(mq.pop_front());
        if (iv && preRdy) mq.push_back(b);
        mRdy = (mq.size() < 2);
      end
    end
    checkOutput("out_valid", {127'd0, out_valid}, {127'd0, mq.size() > 0});
    checkOutput("in_ready", {127'd0, in_ready}, {127'd0, mRdy});
    checkOutput("stall_cnt", {96'd0, stall_cnt}, {96'd0, mStall});
    if (mq.size() > 0) begin
      checkOutput("out_data", out_data, mq[0].data);
      checkOutput("out_reg", {113'd0, out_reg}, {113'd0, mq[0].regs});
      checkOutput("out_ctrl", {112'd0, out_ctrl}, {112'd0, mq[0].ctrl});
    end else begin
      checkOutput("out_ctrl_nop", {112'd0, out_ctrl}, {112'd0, NOP});
    end
  endtask

  vec_t tbl[26];

  initial begin
    beat_t rb;
    logic [31:0] stallExp;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_reg = '0; in_ctrl = '0;

    tbl[0]  = '{1,0,1,1,8'h99,0,0,8'h00};
    tbl[1]  = '{1,0,1,1,8'h99,0,0,8'h00};
    tbl[2]  = '{0,0,0,1,8'h00,0,1,8'h00};
    tbl[3]  = '{0,0,1,1,8'h11,1,1,8'h11};
    tbl[4]  = '{0,0,1,1,8'h22,1,1,8'h22};
    tbl[5]  = '{0,0,1,1,8'h33,1,1,8'h33};
    tbl[6]  = '{0,0,1,1,8'h44,1,1,8'h44};
    tbl[7]  = '{0,0,0,1,8'h00,0,1,8'h00};
    tbl[8]  = '{0,0,1,1,8'hA1,1,1,8'hA1};
    tbl[9]  = '{0,0,1,0,8'hB2,1,0,8'hA1};
    tbl[10] = '{0,0,1,0,8'hC3,1,0,8'hA1};
    tbl[11] = '{0,0,1,0,8'hC3,1,0,8'hA1};
    tbl[12] = '{0,0,1,1,8'hC3,1,1,8'hB2};
    tbl[13] = '{0,0,1,1,8'hC3,1,1,8'hC3};
    tbl[14] = '{0,0,0,1,8'h00,0,1,8'h00};
    tbl[15] = '{0,0,1,0,8'hE1,1,1,8'hE1};
    tbl[16] = '{0,0,1,0,8'hE2,1,0,8'hE1};
    tbl[17] = '{0,1,1,0,8'hDD,0,1,8'h00};
    tbl[18] = '{0,1,1,0,8'hDE,0,1,8'h00};
    tbl[19] = '{0,0,0,1,8'h00,0,1,8'h00};
    tbl[20] = '{0,0,1,0,8'hF1,1,1,8'hF1};
    tbl[21] = '{0,0,1,0,8'hF2,1,0,8'hF1};
    tbl[22] = '{1,0,0,0,8'h00,0,0,8'h00};
    tbl[23] = '{0,0,1,1,8'hEE,0,1,8'h00};
    tbl[24] = '{0,0,1,1,8'hEE,1,1,8'hEE};
    tbl[25] = '{0,0,0,1,8'h00,0,1,8'h00};

    for (int i = 0; i < 26; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ordy, beatFromTag(tbl[i].tag));
      checkOutput($sformatf("vec%0d_out_valid", i), {127'd0, out_valid}, {127'd0, tbl[i].ov});
      checkOutput($sformatf("vec%0d_in_ready", i), {127'd0, in_ready}, {127'd0, tbl[i].ir});
      if (tbl[i].ov)
        checkOutput($sformatf("vec%0d_imm", i), {96'd0, out_data[31:0]}, {120'd0, tbl[i].otag});
      else
        checkOutput($sformatf("vec%0d_ctrl_nop", i), {112'd0, out_ctrl}, {112'd0, NOP});
      if (i == 1) begin
        checkOutput("reset_out_data", out_data, '0);
        checkOutput("reset_out_reg", {113'd0, out_reg}, '0);
        checkOutput("reset_stall_cnt", {96'd0, stall_cnt}, '0);
      end
    end

    // Seven stall cycles, then a flush with out_ready high so the flush cycle itself is not a stall.
`ifdef PIPE_STALL_CNT_EN
    stallExp = 32'd7;
`else
    stallExp = 32'd0;
`endif
    applyStimulus(1, 0, 0, 0, beatFromTag(8'h00));
    applyStimulus(0, 0, 0, 0, beatFromTag(8'h00));
    applyStimulus(0, 0, 1, 0, beatFromTag(8'h57));
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, beatFromTag(8'h00));
    applyStimulus(0, 1, 0, 1, beatFromTag(8'h00));
    checkOutput("stall_after_flush", {96'd0, stall_cnt}, {96'd0, stallExp});
    applyStimulus(0, 0, 0, 0, beatFromTag(8'h00));
    applyStimulus(0, 0, 0, 0, beatFromTag(8'h00));
    checkOutput("stall_held", {96'd0, stall_cnt}, {96'd0, stallExp});

    applyStimulus(1, 0, 0, 0, beatFromTag(8'h00));
    for (int i = 0; i < 400; i++) begin
      rb.data = {$urandom, $urandom, $urandom, $urandom};
      rb.regs = RW'($urandom);
      rb.ctrl = 16'($urandom);
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_skid.md
Name: id_ex_pipe_skid

Overview:
- Parametrised successor to the fixed-field ID/EX register.
- Two-entry pipeline stage (main register plus skid register) carrying bundled data, register-index and control fields between decode and execute.
- Adds a valid/ready handshake on both sides, full throughput under backpressure, flush with bubble injection, and a defined NOP control value.
- Any inter-stage boundary (IF/ID, EX/MEM, MEM/WB) reuses it by changing parameters.

Parameters:
- DATA_W, 32: width of each data field (imm, rs1 data, rs2 data, pc).
- NUM_DATA, 4: number of DATA_W fields.
- REG_W, 5: register-index width.
- NUM_REG, 3: number of index fields (rs1, rs2, rd).
- CTRL_W, 16: width of packed control bundle (Wbsel, MemRw, ALUsel, Asel, Bsel, Rsel, Wsel, immsel).
- CTRL_NOP, 16'h0000: control value presented while out_valid=0 and injected on flush; must encode "no write, no mem access".

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill all held and incoming beats this cycle.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  NUM_DATA*DATA_W  packed data fields, field 0 in LSBs.
- in_reg  in  NUM_REG*REG_W  packed register indices.
- in_ctrl  in  CTRL_W  control bundle.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_DATA*DATA_W  registered data.
- out_reg  out  NUM_REG*REG_W  registered indices.
- out_ctrl  out  CTRL_W  registered control; CTRL_NOP when out_valid=0.
- stall_cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: main_valid=0, skid_valid=0, out_data=0, out_reg=0, out_ctrl=CTRL_NOP, in_ready=0 while rst=1, stall_cnt=0.
- Handshake rules: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready. Payload is held stable while out_valid&~out_ready.
- in_ready: registered, equal to ~skid_valid; never combinationally depends on out_ready.
- Latency: one cycle from input transfer to out_valid; throughput one beat/cycle.
- Main empty or draining: an accepted beat loads main.
- Main full, stalled (out_ready=0), beat accepted: beat goes to skid, skid_valid=1, in_ready=0 next cycle.
- Skid full and main drains: skid moves to main next cycle, skid_valid=0, in_ready=1 next cycle.
- Ordering is strictly FIFO; no beat dropped or duplicated except by flush.
- Flush: next cycle main_valid=0, skid_valid=0, out_ctrl=CTRL_NOP, in_ready=1.
  - A beat accepted in the flush cycle is discarded.
  - out_data/out_reg hold their last values (don't-care while invalid).
- Simultaneous rst and flush: rst wins; values are as at reset.
- rst asserted mid-stream: all held beats lost; out_valid=0 on the next edge.
- While out_valid=0, out_ctrl is forced to CTRL_NOP, so a downstream stage ignoring out_valid sees no side effects.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined: stall_cnt increments each cycle out_valid&~out_ready, saturates at 32'hFFFF_FFFF, clears on rst only (not flush).
- Undefined: stall_cnt tied to 0, no counter logic.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=16'h0000, in_ready=0 during rst, 1 after, stall_cnt=0.
- Streaming: out_ready=1, 4 back-to-back beats with imm 0x11,0x22,0x33,0x44, rd 1..4 -> appear on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Backpressure:
  - Beats A,B,C sent, out_ready=0 from cycle after A -> A held on output, B in skid, in_ready=0, C not accepted.
  - Raise out_ready -> A,B,C emerge in order, no loss.
- Flush: main and skid full, flush=1 with in_valid=1 (beat D) same cycle -> next cycle out_valid=0, out_ctrl=CTRL_NOP, in_ready=1; D never appears.
- Reset mid-op: rst pulse while skid full -> next cycle out_valid=0, in_ready=0, then 1 after rst deasserts; subsequent beat E passes normally.
- PIPE_STALL_CNT_EN defined: 7 stall cycles then flush -> stall_cnt=7 and remains 7. Undefined -> stall_cnt=0 throughout.
